// File: rtl/fifo_level_ctr.sv
// fifo_level_ctr: saturating binary occupancy counter with registered level flags and sticky errors
module fifo_level_ctr #(
  parameter int DEPTH = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST_FIFO_,
  input  logic          INCFIFO,
  input  logic          DECFIFO,
  input  logic          FLUSH,
  input  logic          ERR_CLR,
  output logic [LW-1:0] LEVEL,
  output logic [LW-1:0] SPACE,
  output logic          FIFOEMPTY,
  output logic          FIFOFULL,
  output logic          FIFOAEMPTY,
  output logic          FIFOAFULL,
  output logic          OVERFLOW,
  output logic          UNDERFLOW
);
  localparam logic [LW-1:0] D = LW'(DEPTH);
  localparam logic [LW-1:0] AF = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE = LW'(AE_THRESH);
  if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_params
    $error("fifo_level_ctr: illegal DEPTH/AF_THRESH/AE_THRESH");
  end
  logic [LW-1:0] cnt, nxt;
  logic at_full, at_empty, ovf_set, unf_set;
  assign at_full = cnt == D;
  assign at_empty = cnt == '0;
  assign LEVEL = cnt;
  // next count saturates at both ends; a write paired with a read on empty still lands
  always_comb begin
    nxt = FLUSH ? '0 :
          (INCFIFO && !DECFIFO && !at_full) ? cnt + 1'b1 :
          (DECFIFO && !INCFIFO && !at_empty) ? cnt - 1'b1 :
          (INCFIFO && DECFIFO && at_empty) ? LW'(1) : cnt;
    ovf_set = !FLUSH && INCFIFO && !DECFIFO && at_full;
    unf_set = !FLUSH && DECFIFO && at_empty;
  end
  // count and flags all derive from nxt so they stay consistent every cycle
  always_ff @(posedge CLK or negedge RST_FIFO_) begin
    if (!RST_FIFO_) begin
      cnt <= '0;
      SPACE <= D;
      FIFOEMPTY <= 1'b1;
      FIFOFULL <= 1'b0;
      FIFOAEMPTY <= 1'b1;
      FIFOAFULL <= 1'b0;
      OVERFLOW <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      cnt <= nxt;
      SPACE <= D - nxt;
      FIFOEMPTY <= nxt == '0;
      FIFOFULL <= nxt == D;
      FIFOAEMPTY <= nxt <= AE;
      FIFOAFULL <= nxt >= AF;
      OVERFLOW <= ovf_set | (OVERFLOW & ~ERR_CLR);
      UNDERFLOW <= unf_set | (UNDERFLOW & ~ERR_CLR);
    end
  end
endmodule

// File: tb/tb_fifo_level_ctr.sv
// tb_fifo_level_ctr: directed stimulus, arithmetic occupancy model and per-cycle compare for two parameter sets
module tb_fifo_level_ctr;
  logic clk = 0, rst_n = 0, inc = 0, dec = 0, flush = 0, clr = 0;
  logic [3:0] l1, s1, l2, s2;
  logic e1, f1, ae1, af1, o1, u1, e2, f2, ae2, af2, o2, u2;
  int n_chk = 0, n_fail = 0;
  int m1_l, m2_l;
  bit m1_o, m1_u, m2_o, m2_u;

  always #5 clk = ~clk;

  fifo_level_ctr dut1 (
    .CLK(clk), .RST_FIFO_(rst_n), .INCFIFO(inc), .DECFIFO(dec), .FLUSH(flush), .ERR_CLR(clr),
    .LEVEL(l1), .SPACE(s1), .FIFOEMPTY(e1), .FIFOFULL(f1), .FIFOAEMPTY(ae1), .FIFOAFULL(af1),
    .OVERFLOW(o1), .UNDERFLOW(u1)
  );

  fifo_level_ctr #(.DEPTH(5), .AF_THRESH(5), .AE_THRESH(0)) dut2 (
    .CLK(clk), .RST_FIFO_(rst_n), .INCFIFO(inc), .DECFIFO(dec), .FLUSH(flush), .ERR_CLR(clr),
    .LEVEL(l2[2:0]), .SPACE(s2[2:0]), .FIFOEMPTY(e2), .FIFOFULL(f2), .FIFOAEMPTY(ae2), .FIFOAFULL(af2),
    .OVERFLOW(o2), .UNDERFLOW(u2)
  );
  assign l2[3] = 1'b0;
  assign s2[3] = 1'b0;

  function automatic int model_next(int l, bit i, bit d, bit f, int depth);
    int n;
    if (f) return 0;
    n = l + (i ? 1 : 0) - ((d && l > 0) ? 1 : 0);
    return (n > depth) ? depth : n;
  endfunction

  // reference occupancy: add writes, subtract only reads that find data, clamp at capacity
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_l <= 0; m1_o <= 0; m1_u <= 0;
      m2_l <= 0; m2_o <= 0; m2_u <= 0;
    end else begin
      m1_l <= model_next(m1_l, inc, dec, flush, 8);
      m2_l <= model_next(m2_l, inc, dec, flush, 5);
      m1_o <= (!flush && inc && !dec && m1_l == 8) || (m1_o && !clr);
      m2_o <= (!flush && inc && !dec && m2_l == 5) || (m2_o && !clr);
      m1_u <= (!flush && dec && m1_l == 0) || (m1_u && !clr);
      m2_u <= (!flush && dec && m2_l == 0) || (m2_u && !clr);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // every cycle, both instances against the model
  always @(negedge clk) begin
    chk("m_level1", int'(l1), m1_l);
    chk("m_space1", int'(s1), 8 - m1_l);
    chk("m_empty1", int'(e1), int'(m1_l == 0));
    chk("m_full1", int'(f1), int'(m1_l == 8));
    chk("m_aempty1", int'(ae1), int'(m1_l <= 1));
    chk("m_afull1", int'(af1), int'(m1_l >= 6));
    chk("m_ovf1", int'(o1), int'(m1_o));
    chk("m_unf1", int'(u1), int'(m1_u));
    chk("m_level2", int'(l2), m2_l);
    chk("m_space2", int'(s2), 5 - m2_l);
    chk("m_empty2", int'(e2), int'(m2_l == 0));
    chk("m_full2", int'(f2), int'(m2_l == 5));
    chk("m_aempty2", int'(ae2), int'(m2_l == 0));
    chk("m_afull2", int'(af2), int'(m2_l == 5));
    chk("m_ovf2", int'(o2), int'(m2_o));
    chk("m_unf2", int'(u2), int'(m2_u));
  end

  task automatic cyc(input bit i, input bit d, input bit f, input bit c);
    inc = i; dec = d; flush = f; clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", int'(l1), 0);
    chk("rst_space", int'(s1), 8);
    chk("rst_empty", int'(e1), 1);
    chk("rst_aempty", int'(ae1), 1);
    @(negedge clk);
    rst_n = 1;
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 0, 0);
      chk("fill_level", int'(l1), i);
      chk("fill_afull", int'(af1), int'(i >= 6));
    end
    chk("fill_full", int'(f1), 1);
    chk("fill_space", int'(s1), 0);
    chk("fill_ovf", int'(o1), 0);
    cyc(1, 0, 0, 0);
    chk("ovf_level", int'(l1), 8);
    chk("ovf_set", int'(o1), 1);
    cyc(1, 1, 0, 0);
    chk("full_incdec_level", int'(l1), 8);
    chk("full_incdec_ovf", int'(o1), 1);
    cyc(0, 0, 0, 1);
    chk("ovf_clr", int'(o1), 0);
    for (int i = 7; i >= 0; i--) begin
      cyc(0, 1, 0, 0);
      chk("drain_level", int'(l1), i);
      chk("drain_aempty", int'(ae1), int'(i <= 1));
    end
    chk("drain_empty", int'(e1), 1);
    chk("drain_space", int'(s1), 8);
    chk("drain_unf", int'(u1), 0);
    cyc(0, 1, 0, 0);
    chk("unf_level", int'(l1), 0);
    chk("unf_set", int'(u1), 1);
    cyc(1, 1, 0, 0);
    chk("empty_incdec_level", int'(l1), 1);
    chk("empty_incdec_unf", int'(u1), 1);
    cyc(0, 1, 0, 0);
    chk("dec_to_zero", int'(l1), 0);
    cyc(0, 1, 0, 1);
    chk("unf_set_wins", int'(u1), 1);
    cyc(0, 0, 0, 1);
    chk("unf_clr", int'(u1), 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
    chk("pre_flush_level", int'(l1), 5);
    cyc(1, 0, 1, 0);
    chk("flush_level", int'(l1), 0);
    chk("flush_empty", int'(e1), 1);
    chk("flush_keeps_unf", int'(u1), 1);
    chk("flush_no_ovf", int'(o1), 0);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    chk("pre_rst_level", int'(l1), 4);
    inc = 0;
    #2 rst_n = 0;
    #1;
    chk("async_rst_level", int'(l1), 0);
    chk("async_rst_empty", int'(e1), 1);
    chk("async_rst_space", int'(s1), 8);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 0, 0, 0);
      chk("sw_level", int'(l2), i);
      chk("sw_afull", int'(af2), int'(i == 5));
      chk("sw_afull_eq_full", int'(af2), int'(f2));
    end
    cyc(1, 0, 0, 0);
    chk("sw_ovf", int'(o2), 1);
    chk("sw_d1_level", int'(l1), 6);
    for (int i = 4; i >= 0; i--) begin
      cyc(0, 1, 0, 0);
      chk("sw_drain_level", int'(l2), i);
      chk("sw_aempty", int'(ae2), int'(i == 0));
      chk("sw_aempty_eq_empty", int'(ae2), int'(e2));
    end
    cyc(0, 0, 0, 0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
